// File: rtl/macplus_sdram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : macplus_sdram_pkg
// Description : SDRAM command encodings, controller states and mode-register
//               fields shared by the Mac Plus SDRAM responder.
// Revision    : 1.0 - initial release
// ============================================================================
package macplus_sdram_pkg;

    // Commands as {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_READ      = 4'b0101;
    localparam logic [3:0] CMD_WRITE     = 4'b0100;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_REFRESH   = 4'b0001;
    localparam logic [3:0] CMD_MRS       = 4'b0000;

    localparam int WAIT_W = 14;

    typedef enum logic [3:0] {
        S_INIT_WAIT = 4'd0,
        S_INIT_PRE  = 4'd1,
        S_INIT_REF1 = 4'd2,
        S_INIT_REF2 = 4'd3,
        S_INIT_MRS  = 4'd4,
        S_IDLE      = 4'd5,
        S_ACT       = 4'd6,
        S_RD        = 4'd7,
        S_WR        = 4'd8,
        S_CASW      = 4'd9,
        S_RFSH      = 4'd10,
        S_TAIL      = 4'd11
    } state_t;

    // Mode register fields
    localparam logic [2:0] MRS_RESERVED  = 3'b000;
    localparam logic       MRS_WB_SINGLE = 1'b1;
    localparam logic [1:0] MRS_OPMODE    = 2'b00;
    localparam logic       MRS_BT_SEQ    = 1'b0;
    localparam logic [2:0] MRS_BL_1      = 3'b000;

    function automatic logic [12:0] mrs_word(input logic [2:0] cas);
        return {MRS_RESERVED, MRS_WB_SINGLE, MRS_OPMODE, cas, MRS_BT_SEQ, MRS_BL_1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/macplus_sdram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : macplus_sdram_ctrl
// Description : Single-word SDRAM responder for the Mac Plus RAM bus. Runs
//               power-up init, then serves one read/write/refresh per strobe
//               using auto-precharge. All SDRAM pins are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module macplus_sdram_ctrl
    import macplus_sdram_pkg::*;
#(
    parameter int INIT_WAIT = 10000,
    parameter int T_RCD     = 2,
    parameter int CAS_LAT   = 2,
    parameter int T_RP      = 2,
    parameter int T_RFC     = 7
) (
    input  logic        clk,
    input  logic        _reset,
    input  logic        cycleStart,
    input  logic [20:0] ramAddr,
    input  logic        _ramOE,
    input  logic        _ramWE,
    input  logic        _memoryUDS,
    input  logic        _memoryLDS,
    input  logic        refresh,
    input  logic [15:0] dataIn,
    output logic [15:0] dataOut,
    output logic        dataValid,
    output logic        busy,
    output logic        initDone,
    output logic        overrun,
    output logic        sd_cke,
    output logic        sd_cs_n,
    output logic        sd_ras_n,
    output logic        sd_cas_n,
    output logic        sd_we_n,
    output logic [1:0]  sd_ba,
    output logic [12:0] sd_addr,
    output logic [1:0]  sd_dqm,
    output logic [15:0] sd_dq_out,
    output logic        sd_dq_oe,
    input  logic [15:0] sd_dq_in
);

    // Counter reload values: a state loaded with N lasts N+1 clocks
    localparam logic [WAIT_W-1:0] LD_INIT = WAIT_W'(INIT_WAIT - 1);
    localparam logic [WAIT_W-1:0] LD_RP   = WAIT_W'(T_RP - 1);
    localparam logic [WAIT_W-1:0] LD_RFC  = WAIT_W'(T_RFC - 1);
    localparam logic [WAIT_W-1:0] LD_RCD  = WAIT_W'(T_RCD - 1);
    localparam logic [WAIT_W-1:0] LD_CASW = WAIT_W'(CAS_LAT - 1);
    localparam logic [WAIT_W-1:0] LD_MRS  = WAIT_W'(1);

    state_t            state, state_nx;
    logic [WAIT_W-1:0] cnt, cnt_nx;
    logic              cnt_zero;
    logic [WAIT_W-1:0] cnt_dec;
    logic [3:0]        cmd_nx;
    logic [12:0]       addr_nx;
    logic [1:0]        dqm_nx;
    logic              dq_oe_nx;
    logic [15:0]       dq_out_nx;
    logic [7:0]        col_q, col_nx;
    logic [15:0]       wdata_q, wdata_nx;
    logic [1:0]        be_q, be_nx;
    logic              is_write, is_write_nx;
    logic [15:0]       dout_nx;
    logic              dvalid_nx;
    logic              init_done_nx;
    logic              overrun_nx;

    assign cnt_zero = (cnt == '0);
    assign cnt_dec  = cnt - WAIT_W'(1);
    assign busy     = (state != S_IDLE);

    // Next-state, next-command and latch decode
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        cmd_nx       = CMD_NOP;
        addr_nx      = '0;
        dqm_nx       = 2'b11;
        dq_oe_nx     = 1'b0;
        dq_out_nx    = sd_dq_out;
        col_nx       = col_q;
        wdata_nx     = wdata_q;
        be_nx        = be_q;
        is_write_nx  = is_write;
        dout_nx      = dataOut;
        dvalid_nx    = 1'b0;
        init_done_nx = initDone;
        overrun_nx   = overrun | (cycleStart & (state != S_IDLE));

        case (state)
            S_INIT_WAIT: begin
                // cke is still low on the first clock out of reset: arm the wait
                if (!sd_cke) begin
                    cnt_nx = LD_INIT;
                end else if (cnt_zero) begin
                    state_nx    = S_INIT_PRE;
                    cmd_nx      = CMD_PRECHARGE;
                    addr_nx[10] = 1'b1;
                    cnt_nx      = LD_RP;
                end else begin
                    cnt_nx = cnt_dec;
                end
            end
            S_INIT_PRE: begin
                if (cnt_zero) begin
                    state_nx = S_INIT_REF1;
                    cmd_nx   = CMD_REFRESH;
                    cnt_nx   = LD_RFC;
                end else begin
                    cnt_nx = cnt_dec;
                end
            end
            S_INIT_REF1: begin
                if (cnt_zero) begin
                    state_nx = S_INIT_REF2;
                    cmd_nx   = CMD_REFRESH;
                    cnt_nx   = LD_RFC;
                end else begin
                    cnt_nx = cnt_dec;
                end
            end
            S_INIT_REF2: begin
                if (cnt_zero) begin
                    state_nx = S_INIT_MRS;
                    cmd_nx   = CMD_MRS;
                    addr_nx  = mrs_word(3'(CAS_LAT));
                    cnt_nx   = LD_MRS;
                end else begin
                    cnt_nx = cnt_dec;
                end
            end
            S_INIT_MRS: begin
                if (cnt_zero) begin
                    state_nx     = S_IDLE;
                    init_done_nx = 1'b1;
                end else begin
                    cnt_nx = cnt_dec;
                end
            end
            S_IDLE: begin
                if (cycleStart) begin
                    col_nx   = ramAddr[7:0];
                    wdata_nx = dataIn;
                    be_nx    = {_memoryUDS, _memoryLDS};
                    // Write beats read when both strobes are low
                    if (!_ramWE || !_ramOE) begin
                        is_write_nx = !_ramWE;
                        state_nx    = S_ACT;
                        cmd_nx      = CMD_ACTIVE;
                        addr_nx     = ramAddr[20:8];
                        cnt_nx      = LD_RCD;
                    end else if (refresh) begin
                        state_nx = S_RFSH;
                        cmd_nx   = CMD_REFRESH;
                        cnt_nx   = LD_RFC;
                    end
                end
            end
            S_ACT: begin
                if (cnt_zero) begin
                    addr_nx = {2'b00, 1'b1, 2'b00, col_q};
                    if (is_write) begin
                        state_nx  = S_WR;
                        cmd_nx    = CMD_WRITE;
                        dqm_nx    = be_q;
                        dq_oe_nx  = 1'b1;
                        dq_out_nx = wdata_q;
                    end else begin
                        state_nx = S_RD;
                        cmd_nx   = CMD_READ;
                        dqm_nx   = 2'b00;
                    end
                end else begin
                    cnt_nx = cnt_dec;
                end
            end
            S_RD, S_WR: begin
                state_nx = S_CASW;
                cnt_nx   = LD_CASW;
            end
            S_CASW: begin
                // Writes wait out the same time so every access has one length
                if (cnt_zero) begin
                    state_nx = S_TAIL;
                    if (!is_write) begin
                        dout_nx   = sd_dq_in;
                        dvalid_nx = 1'b1;
                    end
                end else begin
                    cnt_nx = cnt_dec;
                end
            end
            S_TAIL: begin
                state_nx = S_IDLE;
            end
            S_RFSH: begin
                if (cnt_zero) begin
                    state_nx = S_IDLE;
                end else begin
                    cnt_nx = cnt_dec;
                end
            end
            default: begin
                state_nx = S_INIT_WAIT;
                cnt_nx   = '0;
            end
        endcase
    end

    // State, counter, latched request and registered SDRAM pins
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state     <= S_INIT_WAIT;
            cnt       <= '0;
            sd_cke    <= 1'b0;
            {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n} <= CMD_NOP;
            sd_ba     <= 2'b00;
            sd_addr   <= '0;
            sd_dqm    <= 2'b11;
            sd_dq_oe  <= 1'b0;
            sd_dq_out <= '0;
            col_q     <= '0;
            wdata_q   <= '0;
            be_q      <= 2'b11;
            is_write  <= 1'b0;
            dataOut   <= '0;
            dataValid <= 1'b0;
            initDone  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            sd_cke    <= 1'b1;
            {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n} <= cmd_nx;
            sd_ba     <= 2'b00;
            sd_addr   <= addr_nx;
            sd_dqm    <= dqm_nx;
            sd_dq_oe  <= dq_oe_nx;
            sd_dq_out <= dq_out_nx;
            col_q     <= col_nx;
            wdata_q   <= wdata_nx;
            be_q      <= be_nx;
            is_write  <= is_write_nx;
            dataOut   <= dout_nx;
            dataValid <= dvalid_nx;
            initDone  <= init_done_nx;
            overrun   <= overrun_nx;
        end
    end

endmodule
`default_nettype wire
